// File: rtl/sram_axi_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_axi_bridge_pkg : state encodings, IDs and AXI tie-off constants  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sram_axi_bridge_pkg;

   typedef enum logic [0:0] {
      AR_IDLE = 1'b0,
      AR_SEND = 1'b1
   } ar_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_SEND = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   localparam logic [3:0] c_id_inst   = 4'd0;
   localparam logic [3:0] c_id_data   = 4'd1;
   localparam logic [3:0] c_axi_len   = 4'd0;
   localparam logic [1:0] c_axi_burst = 2'b01;
   localparam logic [1:0] c_axi_lock  = 2'b00;
   localparam logic [3:0] c_axi_cache = 4'd0;
   localparam logic [2:0] c_axi_prot  = 3'd0;

   // SRAM-like size codes map directly onto AXI size encodings
   function automatic logic [2:0] axi_size(input logic [1:0] sz);
      return {1'b0, sz};
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_axi_bridge_axi_wr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_wr_ctrl : single-outstanding AXI write with independent AW/W      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module axi_wr_ctrl
   import sram_axi_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   input  logic [1:0]  i_size,
   input  logic [3:0]  i_wstrb,
   input  logic [31:0] i_wdata,
   output logic        o_accept,
   output logic        o_idle,
   output logic        o_resp,
   output logic [31:0] o_awaddr,
   output logic [2:0]  o_awsize,
   output logic        o_awvalid,
   input  logic        i_awready,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   output logic        o_wvalid,
   input  logic        i_wready,
   input  logic        i_bvalid
);

   w_state_t    r_state;
   w_state_t    w_state_nxt;
   logic        r_awvalid;
   logic        r_wvalid;
   logic        w_awvalid_nxt;
   logic        w_wvalid_nxt;
   logic [31:0] r_awaddr;
   logic [2:0]  r_awsize;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= W_IDLE;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_awaddr  <= '0;
         r_awsize  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_awvalid <= w_awvalid_nxt;
         r_wvalid  <= w_wvalid_nxt;
         if (o_accept) begin
            r_awaddr <= i_addr;
            r_awsize <= axi_size(i_size);
            r_wdata  <= i_wdata;
            r_wstrb  <= i_wstrb;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_awvalid_nxt = r_awvalid;
      w_wvalid_nxt  = r_wvalid;
      o_accept      = 1'b0;
      o_resp        = 1'b0;
      case (r_state)
         W_IDLE: begin
            if (i_req) begin
               o_accept      = 1'b1;
               w_state_nxt   = W_SEND;
               w_awvalid_nxt = 1'b1;
               w_wvalid_nxt  = 1'b1;
            end
         end
         W_SEND: begin
            // each channel retires on its own handshake, in any order
            w_awvalid_nxt = r_awvalid & ~i_awready;
            w_wvalid_nxt  = r_wvalid & ~i_wready;
            if (!w_awvalid_nxt && !w_wvalid_nxt) begin
               w_state_nxt = W_RESP;
            end
         end
         W_RESP: begin
            if (i_bvalid) begin
               o_resp      = 1'b1;
               w_state_nxt = W_IDLE;
            end
         end
         default: begin
            w_state_nxt   = W_IDLE;
            w_awvalid_nxt = 1'b0;
            w_wvalid_nxt  = 1'b0;
         end
      endcase
   end

   assign o_idle    = (r_state == W_IDLE);
   assign o_awvalid = r_awvalid;
   assign o_wvalid  = r_wvalid;
   assign o_awaddr  = r_awaddr;
   assign o_awsize  = r_awsize;
   assign o_wdata   = r_wdata;
   assign o_wstrb   = r_wstrb;

endmodule
`default_nettype wire

// File: rtl/sram_axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_axi_bridge : inst/data SRAM-like ports onto one AXI3 master      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sram_axi_bridge
   import sram_axi_bridge_pkg::*;
#(
   parameter logic [3:0] ID_INST = c_id_inst,
   parameter logic [3:0] ID_DATA = c_id_data
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   logic        r_live;
   ar_state_t   r_ar_state;
   ar_state_t   w_ar_state_nxt;
   logic        r_inst_rd_busy;
   logic        r_data_rd_busy;
   logic [31:0] r_araddr;
   logic [2:0]  r_arsize;
   logic [3:0]  r_arid;
   logic        r_ar_is_data;
   logic        w_data_rd_elig;
   logic        w_inst_rd_elig;
   logic        w_data_rd_acc;
   logic        w_inst_acc;
   logic        w_wr_req;
   logic        w_wr_accept;
   logic        w_wr_idle;
   logic        w_wr_resp;
   logic        w_r_inst;
   logic        w_r_data;

   // r_live masks every handshake output while reset is held
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
      end
   end

   assign w_r_inst = r_live & rvalid & (rid == ID_INST);
   assign w_r_data = r_live & rvalid & (rid == ID_DATA);

   // a data read and a write must never be in flight together
   assign w_wr_req = r_live & data_req & data_wr & ~r_data_rd_busy
                   & ~((r_ar_state == AR_SEND) & r_ar_is_data);
   assign w_data_rd_elig = r_live & data_req & ~data_wr & ~r_data_rd_busy
                         & w_wr_idle & ~w_wr_accept;
   assign w_inst_rd_elig = r_live & inst_req & ~r_inst_rd_busy;

   always_comb begin
      w_ar_state_nxt = r_ar_state;
      w_data_rd_acc  = 1'b0;
      w_inst_acc     = 1'b0;
      case (r_ar_state)
         AR_IDLE: begin
            if (w_data_rd_elig) begin
               w_data_rd_acc  = 1'b1;
               w_ar_state_nxt = AR_SEND;
            end else if (w_inst_rd_elig) begin
               w_inst_acc     = 1'b1;
               w_ar_state_nxt = AR_SEND;
            end
         end
         AR_SEND: begin
            if (arready) begin
               w_ar_state_nxt = AR_IDLE;
            end
         end
         default: w_ar_state_nxt = AR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ar_state   <= AR_IDLE;
         r_araddr     <= '0;
         r_arsize     <= '0;
         r_arid       <= '0;
         r_ar_is_data <= 1'b0;
      end else begin
         r_ar_state <= w_ar_state_nxt;
         if (w_data_rd_acc) begin
            r_araddr     <= data_addr;
            r_arsize     <= axi_size(data_size);
            r_arid       <= ID_DATA;
            r_ar_is_data <= 1'b1;
         end else if (w_inst_acc) begin
            r_araddr     <= inst_addr;
            r_arsize     <= axi_size(inst_size);
            r_arid       <= ID_INST;
            r_ar_is_data <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_inst_rd_busy <= 1'b0;
         r_data_rd_busy <= 1'b0;
      end else begin
         if (w_inst_acc) begin
            r_inst_rd_busy <= 1'b1;
         end else if (w_r_inst) begin
            r_inst_rd_busy <= 1'b0;
         end
         if (w_data_rd_acc) begin
            r_data_rd_busy <= 1'b1;
         end else if (w_r_data) begin
            r_data_rd_busy <= 1'b0;
         end
      end
   end

   axi_wr_ctrl u_wr_ctrl (
      .clk       (clk),
      .resetn    (resetn),
      .i_req     (w_wr_req),
      .i_addr    (data_addr),
      .i_size    (data_size),
      .i_wstrb   (data_wstrb),
      .i_wdata   (data_wdata),
      .o_accept  (w_wr_accept),
      .o_idle    (w_wr_idle),
      .o_resp    (w_wr_resp),
      .o_awaddr  (awaddr),
      .o_awsize  (awsize),
      .o_awvalid (awvalid),
      .i_awready (awready),
      .o_wdata   (wdata),
      .o_wstrb   (wstrb),
      .o_wvalid  (wvalid),
      .i_wready  (wready),
      .i_bvalid  (bvalid)
   );

   assign inst_addr_ok = w_inst_acc;
   assign data_addr_ok = w_data_rd_acc | w_wr_accept;
   assign inst_data_ok = w_r_inst;
   assign inst_rdata   = rdata;
   assign data_data_ok = w_r_data | w_wr_resp;
   assign data_rdata   = rdata;

   assign arvalid = (r_ar_state == AR_SEND);
   assign arid    = r_arid;
   assign araddr  = r_araddr;
   assign arsize  = r_arsize;
   assign rready  = r_live;
   assign bready  = r_live;

   assign arlen   = c_axi_len;
   assign arburst = c_axi_burst;
   assign arlock  = c_axi_lock;
   assign arcache = c_axi_cache;
   assign arprot  = c_axi_prot;
   assign awid    = ID_DATA;
   assign awlen   = c_axi_len;
   assign awburst = c_axi_burst;
   assign awlock  = c_axi_lock;
   assign awcache = c_axi_cache;
   assign awprot  = c_axi_prot;
   assign wid     = ID_DATA;
   assign wlast   = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sram_axi_bridge : random traffic vs transaction-level model        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_sram_axi_bridge;

   logic        clk;
   logic        resetn;
   logic        inst_req;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

   int n_vec;
   int n_err;

   // transaction-level view: address slot, per-ID reads in flight, write phase
   logic        m_ar_busy;
   logic [3:0]  m_ar_id;
   logic [31:0] m_ar_addr;
   logic [2:0]  m_ar_size;
   logic        m_inst_out;
   logic        m_data_out;
   logic [1:0]  m_pend;
   int          m_wph;
   logic        m_aw_pend;
   logic        m_w_pend;
   logic [31:0] m_waddr;
   logic [2:0]  m_wsize;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;

   sram_axi_bridge dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
      .arready(arready), .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
      .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_ar_busy  = 1'b0;
      m_ar_id    = '0;
      m_ar_addr  = '0;
      m_ar_size  = '0;
      m_inst_out = 1'b0;
      m_data_out = 1'b0;
      m_pend     = '0;
      m_wph      = 0;
      m_aw_pend  = 1'b0;
      m_w_pend   = 1'b0;
      m_waddr    = '0;
      m_wsize    = '0;
      m_wdata    = '0;
      m_wstrb    = '0;
   endtask

   task automatic drive_idle();
      inst_req = 1'b0; inst_size = 2'd2; inst_addr = '0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = '0;
      data_addr = '0; data_wdata = '0;
      arready = 1'b0; awready = 1'b0; wready = 1'b0;
      rvalid = 1'b0; rid = '0; rdata = '0; bvalid = 1'b0;
   endtask

   task automatic drive_random();
      inst_req   = ($urandom_range(0, 99) < 55);
      inst_size  = 2'($urandom_range(0, 2));
      inst_addr  = $urandom;
      data_req   = ($urandom_range(0, 99) < 55);
      data_wr    = 1'($urandom_range(0, 1));
      data_size  = 2'($urandom_range(0, 2));
      data_wstrb = 4'($urandom);
      data_addr  = $urandom;
      data_wdata = $urandom;
      arready    = ($urandom_range(0, 99) < 60);
      awready    = ($urandom_range(0, 99) < 50);
      wready     = ($urandom_range(0, 99) < 50);
      rvalid     = 1'b0;
      rid        = '0;
      rdata      = $urandom;
      if (m_pend != 2'b00 && $urandom_range(0, 99) < 50) begin
         rvalid = 1'b1;
         if (m_pend == 2'b11) rid = 4'($urandom_range(0, 1));
         else rid = m_pend[1] ? 4'd1 : 4'd0;
      end else if ($urandom_range(0, 99) < 5) begin
         rvalid = 1'b1;
         rid    = 4'($urandom_range(2, 15));
      end
      bvalid = (m_wph == 2) && ($urandom_range(0, 99) < 50);
   endtask

   // compare one cycle's outputs, then advance the model past the next edge
   task automatic evaluate();
      logic e_drd, e_wr, e_inst, e_iok, e_drok, e_dok;
      #1;
      e_drd  = data_req & ~data_wr & ~m_ar_busy & ~m_data_out & (m_wph == 0);
      e_wr   = data_req & data_wr & (m_wph == 0) & ~m_data_out;
      e_inst = inst_req & ~m_ar_busy & ~m_inst_out & ~e_drd;
      e_iok  = rvalid & (rid == 4'd0);
      e_drok = rvalid & (rid == 4'd1);
      e_dok  = e_drok | ((m_wph == 2) & bvalid);

      check("addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'({e_inst, e_drd | e_wr}));
      check("data_ok", 64'({inst_data_ok, data_data_ok}), 64'({e_iok, e_dok}));
      if (e_iok) check("inst_rdata", 64'(inst_rdata), 64'(rdata));
      if (e_drok) check("data_rdata", 64'(data_rdata), 64'(rdata));
      check("arvalid", 64'(arvalid), 64'(m_ar_busy));
      if (m_ar_busy)
         check("ar_fields", 64'({arid, araddr, arsize}), 64'({m_ar_id, m_ar_addr, m_ar_size}));
      check("aw_w_valid", 64'({awvalid, wvalid}),
            64'({(m_wph == 1) & m_aw_pend, (m_wph == 1) & m_w_pend}));
      if ((m_wph == 1) && m_aw_pend)
         check("aw_fields", 64'({awaddr, awsize}), 64'({m_waddr, m_wsize}));
      if ((m_wph == 1) && m_w_pend)
         check("w_fields", 64'({wdata, wstrb}), 64'({m_wdata, m_wstrb}));
      check("ready", 64'({rready, bready}), 64'(2'b11));

      if (m_ar_busy && arready) begin
         m_ar_busy = 1'b0;
         m_pend[m_ar_id[0]] = 1'b1;
      end
      if (e_iok) begin m_inst_out = 1'b0; m_pend[0] = 1'b0; end
      if (e_drok) begin m_data_out = 1'b0; m_pend[1] = 1'b0; end
      if (m_wph == 1) begin
         if (awready) m_aw_pend = 1'b0;
         if (wready) m_w_pend = 1'b0;
         if (!m_aw_pend && !m_w_pend) m_wph = 2;
      end else if (m_wph == 2) begin
         if (bvalid) m_wph = 0;
      end else if (e_wr) begin
         m_wph = 1; m_aw_pend = 1'b1; m_w_pend = 1'b1;
         m_waddr = data_addr; m_wsize = {1'b0, data_size};
         m_wdata = data_wdata; m_wstrb = data_wstrb;
      end
      if (e_drd) begin
         m_ar_busy = 1'b1; m_ar_id = 4'd1; m_ar_addr = data_addr;
         m_ar_size = {1'b0, data_size}; m_data_out = 1'b1;
      end else if (e_inst) begin
         m_ar_busy = 1'b1; m_ar_id = 4'd0; m_ar_addr = inst_addr;
         m_ar_size = {1'b0, inst_size}; m_inst_out = 1'b1;
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ok"}, 64'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 64'(0));
      check({tag, "_valid"}, 64'({arvalid, awvalid, wvalid}), 64'(0));
      check({tag, "_ready"}, 64'({rready, bready}), 64'(0));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      model_reset();
      drive_idle();
      resetn   = 1'b0;
      // requests and responses pending while in reset must all be masked
      inst_req = 1'b1; data_req = 1'b1; rvalid = 1'b1; bvalid = 1'b1;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      drive_idle();
      resetn = 1'b1;
      @(negedge clk);
      #1;
      check("tieoff",
            64'({arlen, arburst, arlock, arcache, arprot, awid, awlen, awburst,
                 awlock, awcache, awprot, wid, wlast}),
            64'({4'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd1, 4'd0, 2'b01,
                 2'b00, 4'd0, 3'd0, 4'd1, 1'b1}));

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         drive_random();
         if (i == 0 || i == 2) begin
            inst_req = 1'b1; inst_addr = 32'h1C00_0000; data_req = 1'b0;
            arready = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
         end
         if (i == 1) arready = 1'b0;
         evaluate();
         if (i == 1) begin
            // abandon an AR in flight and come back cleanly
            #1;
            resetn = 1'b0;
            #1;
            check_quiet("mid_reset");
            model_reset();
            @(negedge clk);
            drive_idle();
            resetn = 1'b1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
